// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg: shared types and constants for the PUF frame UART path.
// Holds the frame-TX FSM state type, sync byte and UART bit framing helper.
package puf_soc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } puf_tx_st_e;

   localparam logic [7:0] PUF_SYNC_BYTE = 8'hA5;
   localparam int         PUF_UART_BITS = 10;

   // Line level of UART bit n: 0 start, 1..8 data LSB first, 9 stop.
   function automatic logic uart_bit(
      input logic [7:0] b,
      input logic [3:0] n
   );
      logic v;
      v = 1'b1;
      if (n == 4'd0)
         v = 1'b0;
      else if (n <= 4'd8)
         v = b[3'(n - 4'd1)];
      return v;
   endfunction

endpackage

// File: rtl/puf_soc_frame_tx_if.sv
// puf_soc_frame_tx_if: frame offer input and UART/status outputs.
// master = frame assembler side, slave = frame transmitter.
interface puf_soc_frame_tx_if #(
   parameter int FRAM_SIZE = 160
);

   logic [FRAM_SIZE-1:0] i_frame;
   logic                 i_frame_valid;
   logic                 o_uart_tx;
   logic                 o_busy;
   logic                 o_tx_done;
   logic                 o_frame_drop;

   modport master (
      output i_frame,
      output i_frame_valid,
      input  o_uart_tx,
      input  o_busy,
      input  o_tx_done,
      input  o_frame_drop
   );

   modport slave (
      input  i_frame,
      input  i_frame_valid,
      output o_uart_tx,
      output o_busy,
      output o_tx_done,
      output o_frame_drop
   );

endinterface

// File: rtl/puf_soc_uart_tx_byte.sv
// puf_soc_uart_tx_byte: one 8N1 byte per start strobe, BAUD_DIV clk per bit.
// done is raised one cycle before the stop bit ends so the next byte follows after a single idle cycle.
module puf_soc_uart_tx_byte
   import puf_soc_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_byte,
   input  logic       i_start,
   output logic       o_done,
   output logic       o_tx
);

   localparam int             CW      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0]  LP_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0]  LP_PRE  = CW'(BAUD_DIV - 2);
   localparam logic [3:0]     LP_STOP = 4'(PUF_UART_BITS - 1);

   logic          r_busy;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_bit;
   logic [7:0]    r_data;
   logic          r_tx;

   // Bit sequencer: baud counter restarts at every start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_bit  <= '0;
         r_data <= '0;
         r_tx   <= 1'b1;
      end else if (i_start && !r_busy) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_bit  <= '0;
         r_data <= i_byte;
         r_tx   <= uart_bit(i_byte, 4'd0);
      end else if (r_busy) begin
         if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
            if (r_bit == LP_STOP) begin
               r_busy <= 1'b0;
               r_bit  <= '0;
               r_tx   <= 1'b1;
            end else begin
               r_bit <= r_bit + 4'd1;
               r_tx  <= uart_bit(r_data, r_bit + 4'd1);
            end
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_done = r_busy && (r_bit == LP_STOP) && (r_cnt == LP_PRE);
   assign o_tx   = r_tx;

endmodule

// File: rtl/puf_soc_frame_tx.sv
// puf_soc_frame_tx: double-buffered PUF frame serializer onto UART 8N1.
// `define PUF_FRAME_TX_CHKSUM_EN adds a 0xA5 sync prefix and XOR checksum suffix.
module puf_soc_frame_tx
   import puf_soc_pkg::*;
#(
   parameter int FRAM_SIZE = 160,
   parameter int BAUD_DIV  = 868
) (
   input  logic              clk,
   input  logic              rst_n,
   puf_soc_frame_tx_if.slave bus
);

   localparam int NB = FRAM_SIZE / 8;
`ifdef PUF_FRAME_TX_CHKSUM_EN
   localparam int NT = NB + 2;
`else
   localparam int NT = NB;
`endif
   localparam int            IW      = $clog2(NB + 2);
   localparam logic [IW-1:0] LP_LAST = IW'(NT);

   puf_tx_st_e           r_state;
   logic [FRAM_SIZE-1:0] r_act;
   logic [FRAM_SIZE-1:0] r_pend;
   logic                 r_pend_vld;
   logic [IW-1:0]        r_idx;
   logic [7:0]           r_byte;
   logic                 r_start;
   logic                 r_tx_done;
   logic                 r_drop;
`ifdef PUF_FRAME_TX_CHKSUM_EN
   logic [7:0]           r_chk;
`endif

   logic          w_done;
   logic          w_tx;
   logic          w_take;
   logic          w_xfer;
   logic          w_free;
   logic [IW-1:0] w_sel;
   logic [7:0]    w_data;
   logic [7:0]    w_byte;

   // An offer loads act_q directly only when fully idle; a pending
   // frame moving to act_q frees the slot in that same cycle.
   assign w_take = (r_state == ST_IDLE) && !r_pend_vld;
   assign w_xfer = ((r_state == ST_IDLE) || (r_state == ST_DONE))
                   && r_pend_vld;
   assign w_free = !r_pend_vld || w_xfer;

`ifdef PUF_FRAME_TX_CHKSUM_EN
   assign w_sel = ((r_idx == '0) || (r_idx > IW'(NB))) ?
                  '0 : r_idx - 1'b1;
`else
   assign w_sel = (r_idx >= IW'(NB)) ? '0 : r_idx;
`endif
   assign w_data = r_act[8*int'(w_sel) +: 8];

   // Byte presented in LOAD: data, or sync/checksum around it.
   always_comb begin
      w_byte = w_data;
`ifdef PUF_FRAME_TX_CHKSUM_EN
      if (r_idx == '0)
         w_byte = PUF_SYNC_BYTE;
      else if (r_idx == IW'(NB + 1))
         w_byte = r_chk;
`endif
   end

   // Top FSM, frame buffers and offer arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_act      <= '0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_idx      <= '0;
         r_byte     <= '0;
         r_start    <= 1'b0;
         r_tx_done  <= 1'b0;
         r_drop     <= 1'b0;
`ifdef PUF_FRAME_TX_CHKSUM_EN
         r_chk      <= '0;
`endif
      end else begin
         r_start   <= 1'b0;
         r_tx_done <= 1'b0;
         r_drop    <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (r_pend_vld) begin
                  r_act      <= r_pend;
                  r_pend_vld <= 1'b0;
                  r_idx      <= '0;
`ifdef PUF_FRAME_TX_CHKSUM_EN
                  r_chk      <= '0;
`endif
                  r_state    <= ST_LOAD;
               end else if (bus.i_frame_valid) begin
                  r_act   <= bus.i_frame;
                  r_idx   <= '0;
`ifdef PUF_FRAME_TX_CHKSUM_EN
                  r_chk   <= '0;
`endif
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_byte  <= w_byte;
               r_start <= 1'b1;
               r_idx   <= r_idx + 1'b1;
`ifdef PUF_FRAME_TX_CHKSUM_EN
               if ((r_idx != '0) && (r_idx <= IW'(NB)))
                  r_chk <= r_chk ^ w_data;
`endif
               r_state <= ST_SEND;
            end
            ST_SEND: begin
               if (w_done)
                  r_state <= (r_idx == LP_LAST) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
               r_tx_done <= 1'b1;
               if (r_pend_vld) begin
                  r_act      <= r_pend;
                  r_pend_vld <= 1'b0;
                  r_idx      <= '0;
`ifdef PUF_FRAME_TX_CHKSUM_EN
                  r_chk      <= '0;
`endif
                  r_state    <= ST_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         if (bus.i_frame_valid && !w_take) begin
            if (w_free) begin
               r_pend     <= bus.i_frame;
               r_pend_vld <= 1'b1;
            end else begin
               r_drop <= 1'b1;
            end
         end
      end
   end

   puf_soc_uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_byte (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_byte  (r_byte),
      .i_start (r_start),
      .o_done  (w_done),
      .o_tx    (w_tx)
   );

   assign bus.o_uart_tx    = w_tx;
   assign bus.o_busy       = (r_state != ST_IDLE) | r_pend_vld;
   assign bus.o_tx_done    = r_tx_done;
   assign bus.o_frame_drop = r_drop;

endmodule
